// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO plus transmit sequencer sitting directly in front of the uart
// core's transmit side. Bytes pushed by the producer are queued and handed
// to the uart one at a time over the transmit / tx_byte / is_transmitting
// handshake. A launched byte stays in the FIFO until the uart acknowledges
// it by raising is_transmitting. If the uart never starts, the same byte is
// re-pulsed after START_TIMEOUT cycles.
//
// Ports
//   clk             single clock, shared with the uart core
//   rst             asynchronous, active-high reset
//   wr_en, wr_data  push one byte per cycle (dropped when full)
//   full, empty     registered occupancy flags
//   count           occupancy, 0..DEPTH
//   overflow        sticky flag: a push was attempted while full
//   clr_overflow    clears overflow (a simultaneous set wins)
//   transmit        one-cycle launch request to the uart core
//   tx_byte         byte presented to the uart core
//   is_transmitting uart core busy flag
//   busy            sequencer is not idle
module uart_tx_fifo #(
  parameter int DEPTH         = 16,
  parameter int AW            = 4,
  parameter int START_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          clr_overflow,
  output logic          transmit,
  output logic [7:0]    tx_byte,
  input  logic          is_transmitting,
  output logic          busy
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [7:0]  TMO_MAX  = START_TIMEOUT[7:0];

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      tmo_cnt;
  logic            push;
  logic            pop;
  logic [AW:0]     count_next;

  // A byte leaves the FIFO only once the uart has actually started on it,
  // so a lost launch can be retried without losing data.
  assign push = wr_en & ~full;
  assign pop  = (state == WAIT_START) & is_transmitting;
  assign busy = (state != IDLE);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // Storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO bookkeeping. Pointers wrap naturally because DEPTH == 2**AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
      // Set has priority over clear so no overflow event is ever missed.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Transmit sequencer. transmit is registered and is high exactly while the
  // state is LAUNCH, so every entry into LAUNCH raises it for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      transmit <= 1'b0;
      tx_byte  <= 8'h00;
      tmo_cnt  <= 8'h00;
    end else begin
      transmit <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty && !is_transmitting) begin
            tx_byte  <= mem[rd_ptr];
            transmit <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          tmo_cnt <= 8'h00;
          state   <= WAIT_START;
        end
        WAIT_START: begin
          if (is_transmitting) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == TMO_MAX) begin
            // uart ignored the request: re-pulse the same byte
            transmit <= 1'b1;
            state    <= LAUNCH;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!is_transmitting) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. The uart side (is_transmitting) is driven
// by the stimulus sequence itself; every expected value is hand-derived.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          clr_overflow;
  logic          transmit;
  logic [7:0]    tx_byte;
  logic          is_transmitting;
  logic          busy;

  int n_vec;
  int n_miss;

  uart_tx_fifo #(
    .DEPTH         (DEPTH),
    .AW            (AW),
    .START_TIMEOUT (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .overflow        (overflow),
    .clr_overflow    (clr_overflow),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Poll for a transmit pulse, bounded.
  task automatic wait_tx(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (transmit === 1'b1) begin
        got = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // Act as the uart for one byte: wait for the launch, start 2 cycles later,
  // stay busy 4 cycles, then go idle.
  task automatic serve(input logic [7:0] exp, input string tag);
    bit got;
    wait_tx(got);
    check({tag, "_launch"}, got, 1);
    check({tag, "_byte"}, tx_byte, exp);
    tick();
    tick();
    is_transmitting = 1'b1;
    repeat (4) tick();
    check({tag, "_hold"}, tx_byte, exp);
    is_transmitting = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    bit got;
    bit seen;
    n_vec  = 0;
    n_miss = 0;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    clr_overflow = 1'b0;
    is_transmitting = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_tx", transmit, 0);
    check("rst_byte", tx_byte, 8'h00);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single push: transmit must appear in cycle N+2 only
    push(8'hA5);
    check("one_n1_count", count, 1);
    check("one_n1_empty", empty, 0);
    check("one_n1_tx", transmit, 0);
    tick();
    check("one_n2_tx", transmit, 1);
    check("one_n2_byte", tx_byte, 8'hA5);
    check("one_n2_busy", busy, 1);
    tick();
    check("one_n3_tx", transmit, 0);
    tick();
    tick();
    is_transmitting = 1'b1;
    tick();
    check("one_pop_count", count, 0);
    check("one_pop_empty", empty, 1);
    check("one_pop_busy", busy, 1);
    tick();
    tick();
    check("one_wd_byte", tx_byte, 8'hA5);
    is_transmitting = 1'b0;
    tick();
    check("one_done_busy", busy, 0);

    // Burst of 16 while uart is busy, then an overflowing 17th push
    is_transmitting = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    check("burst_full", full, 1);
    check("burst_count", count, 16);
    check("burst_ovf0", overflow, 0);
    push(8'hEE);
    check("burst_ovf1", overflow, 1);
    check("burst_cnt16", count, 16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("burst_clr", overflow, 0);
    is_transmitting = 1'b0;
    for (int i = 0; i < 16; i++) serve(8'(i), "burst");
    tick();
    tick();
    check("burst_drained", count, 0);
    check("burst_empty", empty, 1);

    // Push and pop in the same cycle at count 5
    is_transmitting = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    check("pp_count5", count, 5);
    is_transmitting = 1'b0;
    tick();
    check("pp_launch", transmit, 1);
    check("pp_byte", tx_byte, 8'h10);
    tick();
    is_transmitting = 1'b1;
    push(8'h15);
    check("pp_same", count, 5);
    check("pp_noovf", overflow, 0);
    for (int i = 0; i < 11; i++) push(8'h20 + 8'(i));
    check("pp_full", full, 1);
    // Push while full during a pop: byte dropped, overflow set
    is_transmitting = 1'b0;
    tick();
    tick();
    check("pf_launch", transmit, 1);
    check("pf_byte", tx_byte, 8'h11);
    tick();
    is_transmitting = 1'b1;
    push(8'hFF);
    check("pf_count", count, 15);
    check("pf_ovf", overflow, 1);
    check("pf_notfull", full, 0);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("pf_clr", overflow, 0);
    is_transmitting = 1'b0;
    for (int i = 0; i < 4; i++) serve(8'h12 + 8'(i), "pf_drain_a");
    for (int i = 0; i < 11; i++) serve(8'h20 + 8'(i), "pf_drain_b");
    tick();
    tick();
    check("pf_empty", empty, 1);

    // Start timeout: uart never answers, same byte re-pulsed every 10 cycles
    push(8'h5C);
    wait_tx(got);
    check("tmo_first", got, 1);
    check("tmo_byte0", tx_byte, 8'h5C);
    for (int r = 0; r < 3; r++) begin
      seen = 1'b0;
      for (int i = 0; i < 9; i++) begin
        tick();
        if (transmit) seen = 1'b1;
      end
      check("tmo_gap", seen, 0);
      tick();
      check("tmo_repulse", transmit, 1);
      check("tmo_byte", tx_byte, 8'h5C);
      check("tmo_count", count, 1);
    end

    // Reset during WAIT_DONE with 4 bytes queued
    is_transmitting = 1'b1;
    tick();
    tick();
    check("wd_pop", count, 0);
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    check("wd_count4", count, 4);
    check("wd_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("ar_count", count, 0);
    check("ar_empty", empty, 1);
    check("ar_tx", transmit, 0);
    check("ar_byte", tx_byte, 8'h00);
    check("ar_busy", busy, 0);
    tick();
    rst = 1'b0;
    is_transmitting = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (transmit) seen = 1'b1;
    end
    check("ar_no_tx", seen, 0);
    check("ar_idle", busy, 0);
    push(8'h3C);
    wait_tx(got);
    check("ar_new_launch", got, 1);
    check("ar_new_byte", tx_byte, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
